// File: rtl/key_event_ctrl.sv
// Turns debounced button press/release strobes into SHORT / LONG / REPEAT key
// events and queues them in a small show-ahead FIFO drained over valid/ready.
module key_event_ctrl #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          neg_tick,
  input  logic                          pos_tick,
  input  logic [2:0]                    kcode,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [4:0]                    ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          key_held,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] T_SHORT  = 2'b00;
  localparam logic [1:0] T_LONG   = 2'b01;
  localparam logic [1:0] T_REPEAT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_RPT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       code_q;
  logic             key_held_q;

  logic             rel_hit;
  logic             term_long;
  logic             term_rpt;
  logic             push;
  logic [4:0]       push_data;

  // A release of the latched key always beats a terminal count in the same cycle.
  assign rel_hit   = pos_tick && (kcode == code_q);
  assign term_long = (cnt_q == LONG_LAST);
  assign term_rpt  = (cnt_q == RPT_LAST);
  assign push      = ((state_q == S_HELD) && (rel_hit || term_long)) ||
                     ((state_q == S_RPT) && !rel_hit && term_rpt);
  assign push_data = {rel_hit ? T_SHORT : ((state_q == S_HELD) ? T_LONG : T_REPEAT), code_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      key_held_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (neg_tick && (kcode <= 3'd4)) begin
            code_q     <= kcode;
            cnt_q      <= '0;
            state_q    <= S_HELD;
            key_held_q <= 1'b1;
          end
        end
        S_HELD: begin
          if (rel_hit) begin
            state_q    <= S_IDLE;
            key_held_q <= 1'b0;
          end else if (term_long) begin
            cnt_q   <= '0;
            state_q <= S_RPT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RPT: begin
          if (rel_hit) begin
            state_q    <= S_IDLE;
            key_held_q <= 1'b0;
          end else if (term_rpt) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          key_held_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_held = key_held_q;

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          ovf_q;

  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // When full, a write is only allowed if the head leaves in the same cycle.
  assign full  = (fifo_cnt_q == FULL_CNT);
  assign pop   = ev_valid && ev_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ev_valid = (fifo_cnt_q != '0);
  assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : 5'd0;
  assign fifo_cnt = fifo_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sequences the debounced output of the five-button front-end (`buttons`: `pos_tick`, `neg_tick`, `kcode`) into timed key events for the logger UI.
- Classifies each press as SHORT, LONG or auto-REPEAT.
- Queues events in a small FIFO.
- Hands events to the UI processor over a valid/ready handshake. A sticky overflow flag reports dropped events.

Parameters:
- LONG_CYC, 50_000_000, hold cycles before LONG fires (1 s at 50 MHz)
- REPEAT_CYC, 10_000_000, cycles between REPEAT events after LONG (200 ms)
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYC, REPEAT_CYC)
- FIFO_DEPTH, 4, event FIFO entries; power of two

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high; clears all state
- neg_tick  in  1  one-cycle press strobe (switch went low); kcode valid same cycle
- pos_tick  in  1  one-cycle release strobe (switch went high); kcode valid same cycle
- kcode  in  3  button index 0..4; values 5..7 invalid
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_data  out  5  {type[1:0], code[2:0]}; type 00 SHORT, 01 LONG, 10 REPEAT, 11 unused
- fifo_cnt  out  log2(FIFO_DEPTH)+1  entries queued
- key_held  out  1  high while in HELD or RPT
- ovf  out  1  sticky: an event was dropped on a full FIFO
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:

Reset values:
- State IDLE; counter 0; latched code 0.
- FIFO empty: ev_valid=0, ev_data=0, fifo_cnt=0.
- key_held=0, ovf=0.
- Reset asserted mid-hold or mid-repeat aborts immediately. No event is generated for the aborted press, and any queued events are discarded.

FSM, counter `cnt` (CNT_W bits):
- IDLE:
  - neg_tick with kcode<=4: latch code, cnt<=0, go to HELD.
  - neg_tick with kcode>4: ignored.
  - pos_tick: ignored.
- HELD:
  - cnt increments every cycle.
  - pos_tick with kcode==latched code: push SHORT, go to IDLE.
  - Otherwise, when cnt==LONG_CYC-1: push LONG, cnt<=0, go to RPT.
- RPT:
  - cnt increments every cycle.
  - pos_tick with kcode==latched code: go to IDLE with no event.
  - Otherwise, when cnt==REPEAT_CYC-1: push REPEAT, cnt<=0.
- In HELD or RPT, a neg_tick (any code) or a pos_tick of a non-latched code is ignored. First key wins; no rollover.
- pos_tick and neg_tick high in the same cycle: the release is processed first. In IDLE the press is then accepted. In HELD/RPT the press is discarded.
- Release in the same cycle the terminal count is reached: the release wins.
  - In HELD it pushes SHORT (not LONG).
  - In RPT there is no REPEAT.
- key_held = (state != IDLE), registered with the state.

Latency:
- Tick sampled at edge N: the event is written at edge N, and ev_valid/ev_data reflect it in cycle N+1.
- LONG arrives LONG_CYC cycles after the press-tick edge.
- Each REPEAT arrives REPEAT_CYC cycles after the previous LONG/REPEAT.

FIFO:
- Show-ahead: ev_data = head entry whenever ev_valid=1.
- Pop on ev_valid && ev_ready.
- ev_data stays stable while ev_valid && !ev_ready.
- Push when full with no pop in that cycle: event dropped, ovf<=1.
- Push and pop in the same cycle when full: both occur; fifo_cnt unchanged, no drop.
- Push and pop in the same cycle when empty: not possible, because push data is visible only from the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_cnt ranges 0..FIFO_DEPTH.
- ovf_clr and a simultaneous drop: ovf stays 1 (set wins).

Test Plan (LONG_CYC=100, REPEAT_CYC=40, FIFO_DEPTH=4, ev_ready=1 unless stated):
- Short press: neg_tick kcode=2; pos_tick kcode=2 thirty cycles later.
  - Required: one event 5'b00_010, one cycle after the release tick; key_held low afterwards.
- Long hold: neg_tick kcode=4, held 200 cycles, then release.
  - Required: LONG 5'b01_100 at +100 cycles; REPEAT 5'b10_100 at +140 and +180; nothing on release.
- Ignored inputs: hold kcode=1; during the hold, issue neg_tick kcode=3 and pos_tick kcode=0; then release kcode=1 at +50.
  - Required: only SHORT 5'b00_001. Separately, neg_tick kcode=6 in IDLE produces no state change.
- Boundary: pos_tick of the held code on exactly cycle 99 of HELD.
  - Required: SHORT, no LONG.
  - Simultaneous pos/neg ticks in IDLE with kcode=0: the press is accepted and key_held=1.
- Overflow: ev_ready=0; generate 5 SHORT events on codes 0..4.
  - Required: fifo_cnt=4, ovf=1, head=5'b00_000 stable.
  - Then ev_ready=1: codes 0..3 drain in order, and ovf stays set until ovf_clr is pulsed.
- Async reset: assert reset at +60 of a hold with 2 events queued.
  - Required: immediately ev_valid=0, fifo_cnt=0, key_held=0, ovf=0. After reset release, a new press behaves normally.
